// File: rtl/alpha_trim_mean.sv
// Alpha-trimmed mean: sums the ranks TRIM..DN-TRIM-1 of a sorted window serially,
// then divides by the kept count with a bit-serial restoring divider (round half up).
module alpha_trim_mean #(
    parameter int DN   = 25,
    parameter int DW   = 8,
    parameter int IW   = $clog2(DN),
    parameter int TRIM = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [DW*DN-1:0] data_win,
    input  logic [IW*DN-1:0] seq_sorted,
    output logic             busy,
    output logic [DW-1:0]    mean_out,
    output logic             mean_valid
);
    localparam int K   = DN - 2*TRIM;
    localparam int SW  = DW + $clog2(DN) + 1;
    localparam int RW  = $clog2(K) + 1;
    localparam int SCW = $clog2(SW);

    localparam logic [IW-1:0]  CNT_FIRST = IW'(TRIM);
    localparam logic [IW-1:0]  CNT_LAST  = IW'(DN - TRIM - 1);
    localparam logic [SCW-1:0] STEP_LAST = SCW'(SW - 1);
    localparam logic [RW-1:0]  K_R       = RW'(K);
    localparam logic [SW-1:0]  BIAS      = SW'(K >> 1);

    generate
        if (2*TRIM >= DN) begin : g_bad_trim
            $error("alpha_trim_mean: 2*TRIM must be smaller than DN");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, ACCUM, DIV} state_t;

    state_t             state;
    logic [DW*DN-1:0]   data_r;
    logic [IW*DN-1:0]   seq_r;
    logic [IW-1:0]      cnt;
    logic [SCW-1:0]     step;
    logic [SW-1:0]      sum;   // accumulator, then dividend/quotient shift register
    logic [RW-1:0]      rem;

    logic [IW-1:0]      sel_idx;
    logic [DW-1:0]      sample;
    logic [RW-1:0]      rem_sh;
    logic               rem_ge;

    // rem < K always, so dropping its MSB before the shift never loses a bit
    always_comb begin
        sel_idx = seq_r[int'(cnt)*IW +: IW];
        sample  = '0;
        if (int'(sel_idx) < DN)
            sample = data_r[int'(sel_idx)*DW +: DW];
        rem_sh  = {rem[RW-2:0], sum[SW-1]};
        rem_ge  = (rem_sh >= K_R);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            data_r     <= '0;
            seq_r      <= '0;
            cnt        <= '0;
            step       <= '0;
            sum        <= '0;
            rem        <= '0;
            busy       <= 1'b0;
            mean_out   <= '0;
            mean_valid <= 1'b0;
        end else begin
            mean_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_r <= data_win;
                        seq_r  <= seq_sorted;
                        cnt    <= CNT_FIRST;
                        sum    <= BIAS;
                        rem    <= '0;
                        busy   <= 1'b1;
                        state  <= ACCUM;
                    end
                end
                ACCUM: begin
                    sum <= sum + {{(SW-DW){1'b0}}, sample};
                    cnt <= cnt + IW'(1);
                    if (cnt == CNT_LAST) begin
                        step  <= '0;
                        state <= DIV;
                    end
                end
                DIV: begin
                    rem  <= rem_ge ? rem_sh - K_R : rem_sh;
                    sum  <= {sum[SW-2:0], rem_ge};
                    step <= step + SCW'(1);
                    if (step == STEP_LAST) begin
                        mean_out   <= {sum[DW-2:0], rem_ge};
                        mean_valid <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alpha_trim_mean.sv
// Directed bench for alpha_trim_mean: hand-computed trimmed means, latency,
// busy behaviour, dropped/accepted strobes and asynchronous reset mid-divide.
module tb_alpha_trim_mean;
    localparam int DN = 25;
    localparam int DW = 8;
    localparam int IW = $clog2(DN);
    localparam int LAT = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic [DW*DN-1:0] data_win = '0;
    logic [IW*DN-1:0] seq_sorted = '0;
    logic             busy;
    logic [DW-1:0]    mean_out;
    logic             mean_valid;

    int n_chk = 0;
    int n_fail = 0;

    alpha_trim_mean #(.DN(DN), .DW(DW), .TRIM(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .data_win   (data_win),
        .seq_sorted (seq_sorted),
        .busy       (busy),
        .mean_out   (mean_out),
        .mean_valid (mean_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [IW*DN-1:0] ident_seq();
        logic [IW*DN-1:0] s;
        for (int r = 0; r < DN; r++) s[r*IW +: IW] = IW'(r);
        return s;
    endfunction

    // Reference ranking: stable insertion sort of indices by sample value
    function automatic logic [IW*DN-1:0] sort_seq(input logic [DW*DN-1:0] d);
        int idx [DN];
        logic [IW*DN-1:0] s;
        for (int i = 0; i < DN; i++) idx[i] = i;
        for (int i = 1; i < DN; i++) begin
            int key = idx[i];
            int j = i - 1;
            while (j >= 0 && d[idx[j]*DW +: DW] > d[key*DW +: DW]) begin
                idx[j+1] = idx[j];
                j--;
            end
            idx[j+1] = key;
        end
        for (int r = 0; r < DN; r++) s[r*IW +: IW] = IW'(idx[r]);
        return s;
    endfunction

    function automatic logic [DW*DN-1:0] fill(input int v);
        logic [DW*DN-1:0] d;
        for (int i = 0; i < DN; i++) d[i*DW +: DW] = DW'(v);
        return d;
    endfunction

    // Called at a negedge; returns at the first negedge after the sampling edge
    task automatic pulse(input logic [DW*DN-1:0] d, input logic [IW*DN-1:0] s);
        in_valid   = 1'b1;
        data_win   = d;
        seq_sorted = s;
        @(negedge clk);
        in_valid   = 1'b0;
    endtask

    // Waits for mean_valid, lat_start = cycles already elapsed since the strobe edge
    task automatic wait_res(input string tag, input int exp_mean, input int lat_start);
        int lat = lat_start;
        int busy_lo = 0;
        while (!mean_valid && lat < 200) begin
            if (!busy) busy_lo++;
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, LAT);
        check({tag, "_mean"}, int'(mean_out), exp_mean);
        check({tag, "_busy_low_early"}, busy_lo, 0);
        check({tag, "_busy_fall"}, int'(busy), 0);
    endtask

    task automatic count_stray(input string tag, input int cycles);
        int stray = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (mean_valid) stray++;
        end
        check(tag, stray, 0);
    endtask

    initial begin
        logic [DW*DN-1:0] d;
        logic [IW*DN-1:0] s;

        #12;
        check("reset_busy", int'(busy), 0);
        check("reset_mean_out", int'(mean_out), 0);
        check("reset_mean_valid", int'(mean_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // All 100: mean 100, and mean_valid lasts exactly one cycle
        pulse(fill(100), ident_seq());
        wait_res("flat100", 100, 1);
        @(negedge clk);
        check("flat100_valid_one_cycle", int'(mean_valid), 0);
        check("flat100_hold", int'(mean_out), 100);

        // Ramp: kept 4..20, (204+8)/17 = 12
        for (int i = 0; i < DN; i++) d[i*DW +: DW] = DW'(i);
        pulse(d, ident_seq());
        wait_res("ramp", 12, 1);
        @(negedge clk);

        // Outliers: four 0, four 255, seventeen 80 scattered -> 80
        d = fill(80);
        for (int i = 0; i < 4; i++) begin
            d[(i*6)*DW +: DW]   = 8'd0;
            d[(i*6+3)*DW +: DW] = 8'd255;
        end
        pulse(d, sort_seq(d));
        wait_res("outlier", 80, 1);
        @(negedge clk);

        // All 255: (4335+8)/17 = 255, no overflow
        pulse(fill(255), ident_seq());
        wait_res("full255", 255, 1);
        @(negedge clk);

        // Rounding: 16x10 + 19 = 179 -> 11 ; 16x10 + 18 = 178 -> 10
        d = fill(255);
        for (int i = 0; i < 4; i++) d[i*DW +: DW] = 8'd0;
        for (int i = 4; i < 20; i++) d[i*DW +: DW] = 8'd10;
        d[20*DW +: DW] = 8'd19;
        pulse(d, sort_seq(d));
        wait_res("round_up", 11, 1);
        @(negedge clk);
        d[20*DW +: DW] = 8'd18;
        pulse(d, sort_seq(d));
        wait_res("round_down", 10, 1);
        @(negedge clk);

        // Out-of-range index in a kept slot reads as 0: (1600+8)/17 = 94
        s = ident_seq();
        s[10*IW +: IW] = 5'd31;
        pulse(fill(100), s);
        wait_res("bad_index", 94, 1);
        @(negedge clk);

        // Strobe while busy is dropped; only the ramp result appears
        for (int i = 0; i < DN; i++) d[i*DW +: DW] = DW'(i);
        pulse(d, ident_seq());
        repeat (4) @(negedge clk);
        pulse(fill(255), ident_seq());
        wait_res("ignore", 12, 6);
        count_stray("ignore_no_second", 40);

        // Strobe in the mean_valid cycle is accepted
        pulse(fill(100), ident_seq());
        wait_res("b2b_first", 100, 1);
        pulse(fill(200), ident_seq());
        wait_res("b2b_second", 200, 1);
        @(negedge clk);

        // Reset during DIV clears outputs at once and emits nothing
        pulse(fill(50), ident_seq());
        repeat (22) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_mean_out", int'(mean_out), 0);
        check("abort_mean_valid", int'(mean_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        count_stray("abort_no_result", 40);

        for (int i = 0; i < DN; i++) d[i*DW +: DW] = DW'(i);
        pulse(d, ident_seq());
        wait_res("after_reset", 12, 1);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
